// File: rtl/vga_window_color_pkg.sv
// Shared VGA width constants, RGB channel slots and the Win_id width helper
// used by the windowed color assigner and its per-window hit unit.
package vga_window_color_pkg;

  localparam int VGA_COLOR_WIDTH   = 4;
  localparam int VGA_DATA_WIDTH    = 3 * VGA_COLOR_WIDTH;
  localparam int VGA_REZ_MAX_WIDTH = 11;
  localparam int VGA_NUM_WIN       = 2;

  // Channel slots inside a pixel word, counted in units of COLOR_WIDTH.
  localparam int R_LSB = 0;
  localparam int G_LSB = 1;
  localparam int B_LSB = 2;

  function automatic int win_id_width(input int num_win);
    return (num_win < 1) ? 1 : $clog2(num_win + 1);
  endfunction

endpackage

// File: rtl/vga_window_hit.sv
// One window: active bounds register (loaded on commit) and the inclusive
// hit compare; with VGA_WINDOW_BORDER_EN defined it also flags edge pixels.
module vga_window_hit
  import vga_window_color_pkg::*;
#(
  parameter int REZ_MAX_WIDTH = VGA_REZ_MAX_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     commit_i,
  input  logic                     en_i,
  input  logic [REZ_MAX_WIDTH-1:0] h_start_i,
  input  logic [REZ_MAX_WIDTH-1:0] h_end_i,
  input  logic [REZ_MAX_WIDTH-1:0] v_start_i,
  input  logic [REZ_MAX_WIDTH-1:0] v_end_i,
  input  logic [REZ_MAX_WIDTH-1:0] count_h_i,
  input  logic [REZ_MAX_WIDTH-1:0] count_v_i,
  output logic                     hit_o
`ifdef VGA_WINDOW_BORDER_EN
  ,
  output logic                     edge_o
`endif
);

  logic                     en_q, en_d;
  logic [REZ_MAX_WIDTH-1:0] h_start_q, h_start_d;
  logic [REZ_MAX_WIDTH-1:0] h_end_q, h_end_d;
  logic [REZ_MAX_WIDTH-1:0] v_start_q, v_start_d;
  logic [REZ_MAX_WIDTH-1:0] v_end_q, v_end_d;

  always_comb begin
    en_d      = en_q;
    h_start_d = h_start_q;
    h_end_d   = h_end_q;
    v_start_d = v_start_q;
    v_end_d   = v_end_q;
    if (commit_i) begin
      en_d      = en_i;
      h_start_d = h_start_i;
      h_end_d   = h_end_i;
      v_start_d = v_start_i;
      v_end_d   = v_end_i;
    end else begin
      en_d      = en_q;
      h_start_d = h_start_q;
      h_end_d   = h_end_q;
      v_start_d = v_start_q;
      v_end_d   = v_end_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      h_start_q <= '0;
      h_end_q   <= '0;
      v_start_q <= '0;
      v_end_q   <= '0;
    end else begin
      en_q      <= en_d;
      h_start_q <= h_start_d;
      h_end_q   <= h_end_d;
      v_start_q <= v_start_d;
      v_end_q   <= v_end_d;
    end
  end

  // start > end on an axis makes that axis unsatisfiable, so no wrap-around.
  assign hit_o = en_q
              && (count_h_i >= h_start_q) && (count_h_i <= h_end_q)
              && (count_v_i >= v_start_q) && (count_v_i <= v_end_q);

`ifdef VGA_WINDOW_BORDER_EN
  assign edge_o = (count_h_i == h_start_q) || (count_h_i == h_end_q)
               || (count_v_i == v_start_q) || (count_v_i == v_end_q);
`endif

endmodule

// File: rtl/vga_window_color.sv
// Prioritised multi-window color assigner, 2-cycle latency, with geometry
// double-buffered to frame start. Optional border: VGA_WINDOW_BORDER_EN.
module vga_window_color
  import vga_window_color_pkg::*;
#(
  parameter int COLOR_WIDTH   = VGA_COLOR_WIDTH,
  parameter int DATA_WIDTH    = 3 * COLOR_WIDTH,
  parameter int REZ_MAX_WIDTH = VGA_REZ_MAX_WIDTH,
  parameter int NUM_WIN       = VGA_NUM_WIN
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [REZ_MAX_WIDTH-1:0]         Count_h,
  input  logic [REZ_MAX_WIDTH-1:0]         Count_v,
  input  logic [NUM_WIN*DATA_WIDTH-1:0]    Data,
  input  logic [DATA_WIDTH-1:0]            Bg_color,
`ifdef VGA_WINDOW_BORDER_EN
  input  logic [DATA_WIDTH-1:0]            Border_color,
`endif
  input  logic                             Cfg_load,
  input  logic [NUM_WIN*REZ_MAX_WIDTH-1:0] Cfg_h_start,
  input  logic [NUM_WIN*REZ_MAX_WIDTH-1:0] Cfg_h_end,
  input  logic [NUM_WIN*REZ_MAX_WIDTH-1:0] Cfg_v_start,
  input  logic [NUM_WIN*REZ_MAX_WIDTH-1:0] Cfg_v_end,
  input  logic [NUM_WIN-1:0]               Cfg_win_en,
  output logic                             Cfg_pending,
  output logic [COLOR_WIDTH-1:0]           Red,
  output logic [COLOR_WIDTH-1:0]           Green,
  output logic [COLOR_WIDTH-1:0]           Blue,
  output logic [win_id_width(NUM_WIN)-1:0] Win_id
);

  localparam int WID_W = win_id_width(NUM_WIN);
  localparam int RW    = REZ_MAX_WIDTH;
  localparam int DW    = DATA_WIDTH;

  logic                  frame_start_s;
  logic                  commit_s;
  logic                  pending_q, pending_d;
  logic [NUM_WIN*RW-1:0] pend_hs_q, pend_he_q, pend_vs_q, pend_ve_q;
  logic [NUM_WIN-1:0]    pend_en_q;
  logic [NUM_WIN*RW-1:0] src_hs_s, src_he_s, src_vs_s, src_ve_s;
  logic [NUM_WIN-1:0]    src_en_s;

  logic [NUM_WIN-1:0]    hit_s, hit_q;
  logic [NUM_WIN*DW-1:0] data_q;
  logic [DW-1:0]         bg_q;
  logic [DW-1:0]         rgb_d, rgb_q;
  logic [WID_W-1:0]      win_d, win_q;
`ifdef VGA_WINDOW_BORDER_EN
  logic [NUM_WIN-1:0]    edge_s, edge_q;
  logic [DW-1:0]         border_q;
`endif

  assign frame_start_s = (Count_h == '0) && (Count_v == '0);

  // A load coincident with frame start bypasses the pending set entirely.
  assign commit_s = frame_start_s && (Cfg_load || pending_q);
  assign src_hs_s = Cfg_load ? Cfg_h_start : pend_hs_q;
  assign src_he_s = Cfg_load ? Cfg_h_end   : pend_he_q;
  assign src_vs_s = Cfg_load ? Cfg_v_start : pend_vs_q;
  assign src_ve_s = Cfg_load ? Cfg_v_end   : pend_ve_q;
  assign src_en_s = Cfg_load ? Cfg_win_en  : pend_en_q;

  always_comb begin
    pending_d = pending_q;
    if (frame_start_s) begin
      pending_d = 1'b0;
    end else if (Cfg_load) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      pend_hs_q <= '0;
      pend_he_q <= '0;
      pend_vs_q <= '0;
      pend_ve_q <= '0;
      pend_en_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (Cfg_load) begin
        pend_hs_q <= Cfg_h_start;
        pend_he_q <= Cfg_h_end;
        pend_vs_q <= Cfg_v_start;
        pend_ve_q <= Cfg_v_end;
        pend_en_q <= Cfg_win_en;
      end
    end
  end

  for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
    vga_window_hit #(
      .REZ_MAX_WIDTH (RW)
    ) u_hit (
      .clk       (clk),
      .rst_n     (rst_n),
      .commit_i  (commit_s),
      .en_i      (src_en_s[i]),
      .h_start_i (src_hs_s[i*RW +: RW]),
      .h_end_i   (src_he_s[i*RW +: RW]),
      .v_start_i (src_vs_s[i*RW +: RW]),
      .v_end_i   (src_ve_s[i*RW +: RW]),
      .count_h_i (Count_h),
      .count_v_i (Count_v),
      .hit_o     (hit_s[i])
`ifdef VGA_WINDOW_BORDER_EN
      ,
      .edge_o    (edge_s[i])
`endif
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q    <= '0;
      data_q   <= '0;
      bg_q     <= '0;
`ifdef VGA_WINDOW_BORDER_EN
      edge_q   <= '0;
      border_q <= '0;
`endif
    end else begin
      hit_q    <= hit_s;
      data_q   <= Data;
      bg_q     <= Bg_color;
`ifdef VGA_WINDOW_BORDER_EN
      edge_q   <= edge_s;
      border_q <= Border_color;
`endif
    end
  end

  // Scan from the lowest priority upward so window 0 is assigned last and wins.
  always_comb begin
    win_d = WID_W'(NUM_WIN);
    rgb_d = bg_q;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        win_d = WID_W'(i);
`ifdef VGA_WINDOW_BORDER_EN
        rgb_d = edge_q[i] ? border_q : data_q[i*DW +: DW];
`else
        rgb_d = data_q[i*DW +: DW];
`endif
      end else begin
        win_d = win_d;
        rgb_d = rgb_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      win_q <= WID_W'(NUM_WIN);
    end else begin
      rgb_q <= rgb_d;
      win_q <= win_d;
    end
  end

  assign Red         = rgb_q[R_LSB*COLOR_WIDTH +: COLOR_WIDTH];
  assign Green       = rgb_q[G_LSB*COLOR_WIDTH +: COLOR_WIDTH];
  assign Blue        = rgb_q[B_LSB*COLOR_WIDTH +: COLOR_WIDTH];
  assign Win_id      = win_q;
  assign Cfg_pending = pending_q;

endmodule

// File: tb/tb_vga_window_color.sv
// Scoreboard bench for vga_window_color: a frame-level reference model queues
// expected pixels and pending flags; a monitor checks them at fixed latency.
module tb_vga_window_color;
  import vga_window_color_pkg::*;

  localparam int CW = 4;
  localparam int DW = 12;
  localparam int RW = 11;
  localparam int NW = 2;
  localparam int IW = win_id_width(NW);
  localparam int HT = 48;
  localparam int VT = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [RW-1:0]   count_h = '0;
  logic [RW-1:0]   count_v = '0;
  logic [NW*DW-1:0] data = '0;
  logic [DW-1:0]   bg = '0;
`ifdef VGA_WINDOW_BORDER_EN
  logic [DW-1:0]   border = '0;
`endif
  logic            cfg_load = 1'b0;
  logic [NW*RW-1:0] c_hs = '0, c_he = '0, c_vs = '0, c_ve = '0;
  logic [NW-1:0]   c_en = '0;
  logic            cfg_pending;
  logic [CW-1:0]   red, green, blue;
  logic [IW-1:0]   win_id;

  vga_window_color dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Count_h      (count_h),
    .Count_v      (count_v),
    .Data         (data),
    .Bg_color     (bg),
`ifdef VGA_WINDOW_BORDER_EN
    .Border_color (border),
`endif
    .Cfg_load     (cfg_load),
    .Cfg_h_start  (c_hs),
    .Cfg_h_end    (c_he),
    .Cfg_v_start  (c_vs),
    .Cfg_v_end    (c_ve),
    .Cfg_win_en   (c_en),
    .Cfg_pending  (cfg_pending),
    .Red          (red),
    .Green        (green),
    .Blue         (blue),
    .Win_id       (win_id)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [DW-1:0] rgb; int win; } exp_t;
  typedef struct { int due; bit pend; } pexp_t;
  exp_t  q[$];
  pexp_t pq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit fix = 1'b0;

  // Reference model: active and pending window sets as plain integers.
  int a_hs[NW], a_he[NW], a_vs[NW], a_ve[NW];
  bit a_en[NW];
  int p_hs[NW], p_he[NW], p_vs[NW], p_ve[NW];
  bit p_en[NW];
  bit p_flag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NW; i++) begin
      a_hs[i] = 0; a_he[i] = 0; a_vs[i] = 0; a_ve[i] = 0; a_en[i] = 1'b0;
      p_hs[i] = 0; p_he[i] = 0; p_vs[i] = 0; p_ve[i] = 0; p_en[i] = 1'b0;
    end
    p_flag = 1'b0;
  endtask

  task automatic set_win(input int i, input int hs, input int he, input int vs,
                         input int ve, input bit en);
    c_hs[i*RW +: RW] = RW'(hs);
    c_he[i*RW +: RW] = RW'(he);
    c_vs[i*RW +: RW] = RW'(vs);
    c_ve[i*RW +: RW] = RW'(ve);
    c_en[i] = en;
  endtask

  task automatic drive(input int h, input int v, input bit load);
    exp_t  e;
    pexp_t p;
    int    w;
    bit    fs;
    @(negedge clk);
    count_h  = RW'(h);
    count_v  = RW'(v);
    data     = (NW*DW)'($urandom());
    bg       = DW'($urandom());
`ifdef VGA_WINDOW_BORDER_EN
    border   = DW'($urandom());
`endif
    if (fix) begin
      data[DW-1:0] = 12'hABC;
      bg = 12'h000;
    end
    cfg_load = load;
    // Pixel looks up the set that was active before this cycle's commit.
    w = NW;
    for (int i = NW - 1; i >= 0; i--) begin
      if (a_en[i] && h >= a_hs[i] && h <= a_he[i] && v >= a_vs[i] && v <= a_ve[i]) w = i;
    end
    e.due = cyc + 2;
    e.win = w;
    e.rgb = bg;
    if (w < NW) begin
      e.rgb = data[w*DW +: DW];
`ifdef VGA_WINDOW_BORDER_EN
      if (h == a_hs[w] || h == a_he[w] || v == a_vs[w] || v == a_ve[w]) e.rgb = border;
`endif
    end
    q.push_back(e);
    fs = (h == 0) && (v == 0);
    for (int i = 0; i < NW; i++) begin
      if (load && fs) begin
        a_hs[i] = int'(c_hs[i*RW +: RW]); a_he[i] = int'(c_he[i*RW +: RW]);
        a_vs[i] = int'(c_vs[i*RW +: RW]); a_ve[i] = int'(c_ve[i*RW +: RW]);
        a_en[i] = c_en[i];
      end else if (load) begin
        p_hs[i] = int'(c_hs[i*RW +: RW]); p_he[i] = int'(c_he[i*RW +: RW]);
        p_vs[i] = int'(c_vs[i*RW +: RW]); p_ve[i] = int'(c_ve[i*RW +: RW]);
        p_en[i] = c_en[i];
      end else if (fs && p_flag) begin
        a_hs[i] = p_hs[i]; a_he[i] = p_he[i]; a_vs[i] = p_vs[i]; a_ve[i] = p_ve[i];
        a_en[i] = p_en[i];
      end
    end
    if (fs) p_flag = 1'b0;
    else if (load) p_flag = 1'b1;
    p.due  = cyc + 1;
    p.pend = p_flag;
    pq.push_back(p);
  endtask

  task automatic sweep(input int lh, input int lv);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) drive(h, v, (h == lh) && (v == lv));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    cfg_load = 1'b0;
    #1;
    chk("reset_rgb", 32'({blue, green, red}), 32'd0);
    chk("reset_win_id", 32'(win_id), 32'(NW));
    chk("reset_pending", 32'(cfg_pending), 32'd0);
    q.delete();
    pq.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares queued expectations one time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
          exp_t e;
          e = q.pop_front();
          chk("latency", 32'(cyc), 32'(e.due));
          chk("rgb", 32'({blue, green, red}), 32'(e.rgb));
          chk("win_id", 32'(win_id), 32'(e.win));
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
          pexp_t p;
          p = pq.pop_front();
          chk("cfg_pending", 32'(cfg_pending), 32'(p.pend));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    do_reset();
    for (int k = 0; k < 20; k++) drive($urandom_range(0, HT - 1), $urandom_range(1, VT - 1), 1'b0);

    // Single window with fixed data, loaded mid-frame then one full frame.
    set_win(0, 10, 20, 5, 8, 1'b1);
    set_win(1, 0, 0, 0, 0, 1'b0);
    fix = 1'b1;
    drive(30, 2, 1'b1);
    sweep(-1, -1);
    fix = 1'b0;

    // Overlapping windows on line 0.
    set_win(0, 0, 15, 0, 0, 1'b1);
    set_win(1, 10, 30, 0, 0, 1'b1);
    sweep(0, 0);

    // Mid-frame load keeps the old geometry until the next frame start.
    set_win(0, 20, 25, 0, 3, 1'b1);
    set_win(1, 0, 0, 0, 0, 1'b0);
    drive(100, 50, 1'b1);
    for (int h = 1; h < HT; h++) drive(h, 0, 1'b0);
    sweep(-1, -1);

    // Degenerate horizontal extent, loaded at frame start.
    set_win(0, 30, 20, 0, 9, 1'b1);
    sweep(0, 0);

    // Wide window up to coordinate 1023.
    set_win(0, 0, 1023, 0, 9, 1'b1);
    drive(0, 0, 1'b1);
    drive(1023, 3, 1'b0);
    drive(1022, 3, 1'b0);
    drive(1024, 3, 1'b0);
    drive(2047, 9, 1'b0);
    drive(1023, 10, 1'b0);

    // Border geometry, then randomized configurations and load timing.
    set_win(0, 10, 20, 5, 8, 1'b1);
    set_win(1, 5, 40, 2, 9, 1'b1);
    sweep(0, 0);
    for (int f = 0; f < 10; f++) begin
      int lh, lv;
      for (int i = 0; i < NW; i++) begin
        set_win(i, $urandom_range(0, HT - 1), $urandom_range(0, HT - 1),
                $urandom_range(0, VT - 1), $urandom_range(0, VT - 1),
                $urandom_range(0, 3) != 0);
      end
      lh = $urandom_range(0, HT - 1);
      lv = $urandom_range(0, VT - 1);
      if ($urandom_range(0, 3) == 0) lh = -1;
      sweep(lh, lv);
      if (f == 5) begin
        do_reset();
        sweep(-1, -1);
      end
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size() + pq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
